// File: rtl/axi_lite_master_pkg.sv
// Shared definitions for the AXI-Lite initiator: response codes and FSM encoding.
package axi_lite_master_pkg;

  localparam logic RESP_OKAY = 1'b1;
  localparam logic RESP_ERR  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// Single-beat AXI-Lite initiator with bounded retry on error responses.
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int MAX_RETRY = 3,
  parameter int CNT_WDTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_WDTH-1:0] cmd_addr,
  input  logic [DATA_WDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_WDTH-1:0] rsp_rdata,
  output logic                 rsp_ok,
  output logic [CNT_WDTH-1:0]  rsp_retries,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp
);

  state_e                 r_state, w_nxt;
  logic [ADDR_WDTH-1:0]   r_addr;
  logic [DATA_WDTH-1:0]   r_wdata;
  logic [CNT_WDTH-1:0]    r_cnt;
  logic                   r_aw_done, r_w_done;
  logic [DATA_WDTH-1:0]   r_rsp_rdata;
  logic                   r_rsp_ok;

  logic w_cnt_max, w_rd_ok, w_wr_ok, w_aw_fin, w_w_fin;

  assign w_cnt_max = (r_cnt == CNT_WDTH'(MAX_RETRY));
  assign w_rd_ok   = (r_resp[0] == RESP_OKAY);
  assign w_wr_ok   = (b_resp[0] == RESP_OKAY);
  assign w_aw_fin  = r_aw_done | aw_ready;
  assign w_w_fin   = r_w_done  | w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_nxt = cmd_write ? ST_WR_REQ : ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) w_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        r_ready = 1'b1;
        if (r_valid) w_nxt = (w_rd_ok || w_cnt_max) ? ST_DONE : ST_RD_ADDR;
      end
      ST_WR_REQ: begin
        // Each channel's valid falls independently once its own handshake lands.
        aw_valid = ~r_aw_done;
        w_valid  = ~r_w_done;
        if (w_aw_fin && w_w_fin) w_nxt = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        b_ready = 1'b1;
        if (b_valid) w_nxt = (w_wr_ok || w_cnt_max) ? ST_DONE : ST_WR_REQ;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_ok    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (cmd_valid) begin
          r_addr    <= cmd_addr;
          r_wdata   <= cmd_wdata;
          r_cnt     <= '0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        ST_RD_DATA: if (r_valid) begin
          r_rsp_rdata <= r_data;
          r_rsp_ok    <= w_rd_ok;
          if (!w_rd_ok && !w_cnt_max) r_cnt <= r_cnt + CNT_WDTH'(1);
        end
        ST_WR_REQ: begin
          if (aw_ready) r_aw_done <= 1'b1;
          if (w_ready)  r_w_done  <= 1'b1;
        end
        ST_WR_RESP: if (b_valid) begin
          r_rsp_rdata <= '0;
          r_rsp_ok    <= w_wr_ok;
          // Retry re-enters WR_REQ, so re-arm both channel flags here.
          if (!w_wr_ok && !w_cnt_max) begin
            r_cnt     <= r_cnt + CNT_WDTH'(1);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ar_address  = r_addr;
  assign aw_address  = r_addr;
  assign w_data      = r_wdata;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_ok      = r_rsp_ok;
  assign rsp_retries = r_cnt;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a configurable AXI-Lite slave model.
module tb_axi_lite_master;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_ok;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_retries;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]  ar_address, aw_address;
  logic [31:0] r_data, w_data;
  logic [0:0]  r_resp, b_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;

  axi_lite_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_ok(rsp_ok), .rsp_retries(rsp_retries),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cfg_errs = 0, cfg_r_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0;
  logic [31:0] cfg_rdata = '0;
  int n_ar, n_r, n_aw, n_w, n_b;
  logic [3:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic [63:0] hist_aw, hist_w;
  int rr_cnt, lat;

  // Slave model: readies and responses change only on the falling edge.
  initial begin
    int r_age, aw_age, w_age;
    bit r_pend, b_pend, got_aw, got_w;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    r_age = 0; aw_age = 0; w_age = 0;
    r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
        r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
        r_age = 0; aw_age = 0; w_age = 0;
        continue;
      end
      b_valid = b_pend;
      b_resp  = (n_b < cfg_errs) ? 1'b0 : 1'b1;
      if (b_valid && b_ready) begin n_b++; b_pend = 0; end
      r_valid = r_pend && (r_age >= cfg_r_dly);
      r_data  = cfg_rdata;
      r_resp  = (n_r < cfg_errs) ? 1'b0 : 1'b1;
      if (r_valid && r_ready) begin n_r++; r_pend = 0; end
      else if (r_pend) r_age++;
      ar_ready = ar_valid;
      if (ar_valid) begin n_ar++; r_pend = 1; r_age = 0; end
      aw_ready = aw_valid && (aw_age >= cfg_aw_dly);
      if (aw_ready) begin n_aw++; got_aw = 1; cap_addr = aw_address; aw_age = 0; end
      else if (aw_valid) aw_age++;
      else aw_age = 0;
      w_ready = w_valid && (w_age >= cfg_w_dly);
      if (w_ready) begin n_w++; got_w = 1; cap_wdata = w_data; w_age = 0; end
      else if (w_valid) w_age++;
      else w_age = 0;
      if (got_aw && got_w) begin b_pend = 1; got_aw = 0; got_w = 0; end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rec();
    if (lat < 64) begin hist_aw[lat] = aw_valid; hist_w[lat] = w_valid; end
    if (r_ready) rr_cnt++;
  endtask

  task automatic new_test(input int errs, input int rdly, input int awd, input int wd,
                          input logic [31:0] rd);
    cfg_errs = errs; cfg_r_dly = rdly; cfg_aw_dly = awd; cfg_w_dly = wd; cfg_rdata = rd;
    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
    hist_aw = '0; hist_w = '0; rr_cnt = 0;
  endtask

  // lat = posedges from the accepting edge (inclusive) until rsp_valid is seen.
  task automatic run_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 0;
    lat = 1; rec();
    while (!rsp_valid && lat < 60) begin tick(); lat++; rec(); end
    chk("rsp_valid_seen", 32'(rsp_valid), 1);
  endtask

  task automatic consume();
    rsp_ready = 1; tick(); rsp_ready = 0;
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
  endtask

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
    new_test(0, 0, 0, 0, 32'h0);
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_valids", 32'({rsp_valid, ar_valid, r_ready, aw_valid, w_valid, b_ready}), 0);
    chk("rst_rsp", 32'({rsp_ok, rsp_retries}), 0);
    chk("rst_rdata", rsp_rdata, 0);
    @(negedge clk); @(posedge clk); #1 rst_n = 1;
    tick();

    // Zero-wait OKAY write
    new_test(0, 0, 0, 0, 32'h0);
    run_cmd(1'b1, 4'h3, 32'hDEADBEEF);
    chk("wr_lat", 32'(lat), 3);
    chk("wr_n_aw", 32'(n_aw), 1);
    chk("wr_n_w", 32'(n_w), 1);
    chk("wr_aw_addr", 32'(cap_addr), 32'h3);
    chk("wr_wdata", cap_wdata, 32'hDEADBEEF);
    chk("wr_ok", 32'(rsp_ok), 1);
    chk("wr_retries", 32'(rsp_retries), 0);
    chk("wr_rdata", rsp_rdata, 0);
    chk("done_cmd_ready", 32'(cmd_ready), 0);
    consume();

    // Read with r_valid held off 5 cycles
    new_test(0, 5, 0, 0, 32'hDEADBEEF);
    run_cmd(1'b0, 4'h3, 32'h0);
    chk("rd_lat", 32'(lat), 8);
    chk("rd_rready_cycles", 32'(rr_cnt), 6);
    chk("rd_n_ar", 32'(n_ar), 1);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_ok", 32'(rsp_ok), 1);
    chk("rd_retries", 32'(rsp_retries), 0);
    consume();

    // Write: one error then OKAY
    new_test(1, 0, 0, 0, 32'h0);
    run_cmd(1'b1, 4'h7, 32'h0BAD_F00D);
    chk("wre_n_aw", 32'(n_aw), 2);
    chk("wre_n_w", 32'(n_w), 2);
    chk("wre_n_b", 32'(n_b), 2);
    chk("wre_ok", 32'(rsp_ok), 1);
    chk("wre_retries", 32'(rsp_retries), 1);
    consume();

    // Read: persistent error exhausts retries
    new_test(99, 0, 0, 0, 32'h12345678);
    run_cmd(1'b0, 4'hA, 32'h0);
    chk("rdx_n_ar", 32'(n_ar), 4);
    chk("rdx_ok", 32'(rsp_ok), 0);
    chk("rdx_retries", 32'(rsp_retries), 3);
    chk("rdx_rdata", rsp_rdata, 32'h12345678);
    consume();

    // Write: W lags AW by 2 cycles
    new_test(0, 0, 0, 2, 32'h0);
    run_cmd(1'b1, 4'h1, 32'h1111_2222);
    chk("skew_lat", 32'(lat), 5);
    chk("skew_aw_hist", 32'(hist_aw[4:1]), 32'b0001);
    chk("skew_w_hist", 32'(hist_w[4:1]), 32'b0111);
    chk("skew_n", 32'({n_aw[3:0], n_w[3:0]}), 32'h11);
    chk("skew_ok", 32'(rsp_ok), 1);
    consume();

    // Write: AW lags W by 2 cycles
    new_test(0, 0, 2, 0, 32'h0);
    run_cmd(1'b1, 4'h2, 32'h3333_4444);
    chk("rskew_lat", 32'(lat), 5);
    chk("rskew_aw_hist", 32'(hist_aw[4:1]), 32'b0111);
    chk("rskew_w_hist", 32'(hist_w[4:1]), 32'b0001);
    chk("rskew_wdata", cap_wdata, 32'h3333_4444);
    chk("rskew_ok", 32'(rsp_ok), 1);
    consume();

    // Response back-pressure
    new_test(0, 0, 0, 0, 32'hA5A5_0F0F);
    run_cmd(1'b0, 4'hC, 32'h0);
    chk("bp_lat", 32'(lat), 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rdata", rsp_rdata, 32'hA5A5_0F0F);
      chk("bp_cmd_ready", 32'(cmd_ready), 0);
    end
    consume();

    // Reset pulse while waiting in RD_DATA
    new_test(0, 20, 0, 0, 32'h5555_AAAA);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h9;
    tick(); cmd_valid = 0;
    tick(); tick();
    chk("pre_rst_r_ready", 32'(r_ready), 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("mid_rst_valids", 32'({rsp_valid, ar_valid, r_ready, aw_valid, w_valid, b_ready}), 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_rsp", 32'({rsp_ok, rsp_retries}), 0);
    @(negedge clk); @(posedge clk); #1 rst_n = 1;
    tick();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Recovery read after reset
    new_test(0, 0, 0, 0, 32'hCAFE_F00D);
    run_cmd(1'b0, 4'h5, 32'h0);
    chk("rec_lat", 32'(lat), 3);
    chk("rec_n_ar", 32'(n_ar), 1);
    chk("rec_rdata", rsp_rdata, 32'hCAFE_F00D);
    chk("rec_ok", 32'(rsp_ok), 1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
